// File: rtl/flag_reg_unit.sv
// flag_reg_unit: NZCV flag register with forwarding view and optional shadow save stack.
// Define FLAG_SHADOW_EN to build the SHADOW_DEPTH-entry push/pop stack.
module flag_reg_unit #(
    parameter int SHADOW_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       stall,
    input  logic       flush,
    input  logic       cond_pass,
    input  logic [1:0] flag_we,
    input  logic [3:0] alu_flags,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] flags_q,
    output logic [3:0] flags_fwd,
    output logic       shadow_full,
    output logic       shadow_empty,
    output logic       shadow_err
);
    logic wr;
    assign wr = cond_pass & ~stall & ~flush;
    assign flags_fwd = {wr & flag_we[1] ? alu_flags[3:2] : flags_q[3:2],
                        wr & flag_we[0] ? alu_flags[1:0] : flags_q[1:0]};
`ifdef FLAG_SHADOW_EN
    localparam int CW = $clog2(SHADOW_DEPTH + 1);
    localparam int IW = SHADOW_DEPTH > 1 ? $clog2(SHADOW_DEPTH) : 1;
    logic [CW-1:0] count, top;
    logic [3:0]    stack [SHADOW_DEPTH];
    logic          do_push, do_pop;
    assign top          = count - CW'(1);
    assign shadow_full  = count == CW'(SHADOW_DEPTH);
    assign shadow_empty = count == '0;
    assign do_push      = ~stall & push & ~pop & ~shadow_full;
    assign do_pop       = ~stall & pop & ~push & ~shadow_empty;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            flags_q    <= '0;
            count      <= '0;
            shadow_err <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) stack[i] <= '0;
        end else begin
            shadow_err <= ~stall & ((push & pop) | (push & shadow_full) | (pop & shadow_empty));
            // a restore from the stack overrides any same-cycle ALU flag write
            if (!stall) flags_q <= do_pop ? stack[top[IW-1:0]] : flags_fwd;
            if (do_push) begin
                stack[count[IW-1:0]] <= flags_fwd;
                count                <= count + CW'(1);
            end else if (do_pop) begin
                count <= top;
            end
        end
`else
    logic unused_shadow;
    assign unused_shadow = push ^ pop;
    assign shadow_full   = 1'b0;
    assign shadow_empty  = 1'b1;
    assign shadow_err    = 1'b0;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) flags_q <= '0;
        else          flags_q <= flags_fwd;
`endif
endmodule
